// File: rtl/bus_gate_arbiter.sv
// Round-robin owner of the four bus gate selects; guarantees one-hot-or-zero gates,
// a dead turnaround cycle between owners, and watchdog release of a stuck owner.
//
// state | meaning
// IDLE  | no owner, arbitrate every cycle
// OWN   | one requester holds its gate, tenure counter running
// TURN  | one all-zero bus cycle after a release, arbitrates like IDLE
module bus_gate_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] req,
    input  logic [3:0] done,
    input  logic       err_clr,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout_err,
    output logic [1:0] err_idx
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [1:0]    owner;
    logic [CW-1:0] cnt;

    logic          found;
    logic [1:0]    win_idx;
    logic [1:0]    idx;
    logic          rel_done;
    logic          rel_drop;
    logic          rel_tmo;
    logic          release_now;
    logic          tmo_fire;

    // Rotating search starting at ptr; the first requester found wins.
    always_comb begin
        found   = 1'b0;
        win_idx = 2'd0;
        idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        rel_done    = done[owner];
        rel_drop    = !req[owner];
        rel_tmo     = (cnt == CNT_LAST);
        release_now = (state == OWN) && (rel_done || rel_drop || rel_tmo);
        // A done or a dropped request in the watchdog cycle is a clean release.
        tmo_fire    = (state == OWN) && rel_tmo && !rel_done && !rel_drop;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            ptr         <= 2'd3;
            owner       <= 2'd0;
            cnt         <= '0;
            grant       <= 4'b0000;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            err_idx     <= 2'd0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (found) begin
                        state <= OWN;
                        grant <= 4'b0001 << win_idx;
                        owner <= win_idx;
                        ptr   <= win_idx + 2'd1;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        grant <= 4'b0000;
                        busy  <= 1'b0;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        state <= TURN;
                        grant <= 4'b0000;
                        busy  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase

            if (tmo_fire) begin
                timeout_err <= 1'b1;
                err_idx     <= owner;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign GatePC     = grant[3];
    assign GateMDR    = grant[2];
    assign GateALU    = grant[1];
    assign GateMARMUX = grant[0];

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed and random checks of bus_gate_arbiter grant sequencing, turnaround,
// watchdog release and asynchronous reset.
module tb_bus_gate_arbiter;

    logic       Clk;
    logic       Reset;
    logic [3:0] req;
    logic [3:0] done;
    logic       err_clr;
    logic       GatePC;
    logic       GateMDR;
    logic       GateALU;
    logic       GateMARMUX;
    logic [3:0] grant;
    logic       busy;
    logic       timeout_err;
    logic [1:0] err_idx;

    int errors;
    int checks;

    bus_gate_arbiter #(.TIMEOUT(16)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req        (req),
        .done       (done),
        .err_clr    (err_clr),
        .GatePC     (GatePC),
        .GateMDR    (GateMDR),
        .GateALU    (GateALU),
        .GateMARMUX (GateMARMUX),
        .grant      (grant),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_idx    (err_idx)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    logic [3:0] rr_seq [5];
    logic [3:0] prev_grant;
    int         hi;
    logic       err_early;

    initial begin
        errors  = 0;
        checks  = 0;
        Reset   = 1'b1;
        req     = 4'b0000;
        done    = 4'b0000;
        err_clr = 1'b0;
        rr_seq  = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        repeat (3) step();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_gates", {GatePC, GateMDR, GateALU, GateMARMUX}, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", timeout_err, 1'b0);
        chk("rst_erridx", err_idx, 2'd0);
        Reset = 1'b0;

        // round robin with all requesting, done on first OWN cycle
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("rr_grant%0d", k), grant, rr_seq[k]);
            chk($sformatf("rr_gates%0d", k), {GatePC, GateMDR, GateALU, GateMARMUX}, rr_seq[k]);
            done = rr_seq[k];
            step();
            chk($sformatf("rr_turn%0d", k), grant, 4'b0000);
            chk($sformatf("rr_tbusy%0d", k), busy, 1'b1);
            done = 4'b0000;
            if (k == 4) req = 4'b0000;
        end
        step();
        chk("rr_idle_busy", busy, 1'b0);

        // ALU alone, done in its third cycle
        req = 4'b0010;
        step();
        chk("alu_c1", GateALU, 1'b1);
        chk("alu_busy1", busy, 1'b1);
        step();
        chk("alu_c2", GateALU, 1'b1);
        step();
        chk("alu_c3", GateALU, 1'b1);
        done = 4'b0010;
        step();
        chk("alu_turn_gate", GateALU, 1'b0);
        chk("alu_turn_busy", busy, 1'b1);
        req  = 4'b0000;
        done = 4'b0000;
        step();
        chk("alu_idle_busy", busy, 1'b0);
        chk("alu_idle_grant", grant, 4'b0000);

        // MDR held with no done: watchdog release after 16 cycles
        req       = 4'b0100;
        hi        = 0;
        err_early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (GateMDR) begin
                hi++;
                if (timeout_err) err_early = 1'b1;
            end else if (hi > 0) begin
                break;
            end
        end
        chk("tmo_cycles", hi, 16);
        chk("tmo_err_early", err_early, 1'b0);
        chk("tmo_err", timeout_err, 1'b1);
        chk("tmo_erridx", err_idx, 2'd2);
        chk("tmo_turn_busy", busy, 1'b1);
        req     = 4'b0000;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err", timeout_err, 1'b0);
        chk("clr_erridx", err_idx, 2'd2);

        // done coinciding with the watchdog cycle is a clean release
        req = 4'b0100;
        step();
        repeat (15) step();
        chk("dt_gate16", GateMDR, 1'b1);
        done = 4'b0100;
        step();
        chk("dt_release", GateMDR, 1'b0);
        chk("dt_noerr", timeout_err, 1'b0);
        req  = 4'b0000;
        done = 4'b0000;
        step();

        // owner drops req; non-owner done ignored
        req = 4'b1000;
        step();
        chk("drop_grant", grant, 4'b1000);
        done = 4'b0111;
        step();
        chk("nonowner_done", grant, 4'b1000);
        req  = 4'b0000;
        done = 4'b0000;
        step();
        chk("drop_release", grant, 4'b0000);
        chk("drop_busy", busy, 1'b1);
        chk("drop_noerr", timeout_err, 1'b0);
        step();
        chk("drop_idle", busy, 1'b0);

        // async reset in PC's second OWN cycle
        req = 4'b1000;
        step();
        step();
        chk("pre_rst_pc", GatePC, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_gates", {GatePC, GateMDR, GateALU, GateMARMUX}, 4'b0000);
        chk("async_grant", grant, 4'b0000);
        chk("async_busy", busy, 1'b0);
        req = 4'b1001;
        step();
        Reset = 1'b0;
        step();
        chk("post_rst_pc_first", grant, 4'b1000);
        req = 4'b0000;
        step();
        step();

        // random traffic: one-hot, gate mirror, no direct handover
        prev_grant = grant;
        for (int i = 0; i < 10000; i++) begin
            req  = 4'($urandom);
            done = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            step();
            chk("rnd_onehot", $onehot0(grant), 1'b1);
            chk("rnd_gates", {GatePC, GateMDR, GateALU, GateMARMUX}, grant);
            chk("rnd_handover",
                (prev_grant != 4'b0000) && (grant != 4'b0000) && (grant != prev_grant), 1'b0);
            prev_grant = grant;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
